// File: rtl/xbar_pkg.sv
// Shared crossbar types: reorder-buffer bank state and the default lane view.
package xbar_pkg;

  localparam int XBAR_SIZE     = 8;
  localparam int XBAR_DWIDTH   = 32;
  localparam int XBAR_TAGWIDTH = $clog2(XBAR_SIZE);

  // Life cycle of one reassembly bank.
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } reorder_state_e;

  // One sorter lane as seen on the return path (default configuration widths).
  typedef struct packed {
    logic [XBAR_DWIDTH-1:0]   din;
    logic [XBAR_TAGWIDTH-1:0] tag;
    logic                     vld;
  } lane_t;

endpackage

// File: rtl/xbar_reorder_bank.sv
// One reassembly bank: entry storage, written-mask, EMPTY/FILLING/FULL FSM,
// lowest-lane-wins write select and dropped-write (collision) detection.
module xbar_reorder_bank
  import xbar_pkg::*;
#(
  parameter int SIZE     = XBAR_SIZE,
  parameter int DWIDTH   = XBAR_DWIDTH,
  parameter int TAGWIDTH = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [SIZE-1:0]          lane_valid,
  input  logic [SIZE*DWIDTH-1:0]   data,
  input  logic [SIZE*TAGWIDTH-1:0] tag,
  input  logic                     last,
  input  logic                     rd_en,
  output reorder_state_e           state,
  output logic [SIZE-1:0]          mask,
  output logic [SIZE*DWIDTH-1:0]   entries,
  output logic                     closing,
  output logic                     collision
);

  reorder_state_e                 state_r;
  reorder_state_e                 state_nxt_s;
  logic [SIZE-1:0]                mask_r;
  logic [SIZE-1:0]                mask_nxt_s;
  logic [SIZE-1:0][DWIDTH-1:0]    store_r;
  logic [SIZE-1:0]                wr_hit_s;
  logic [SIZE-1:0][DWIDTH-1:0]    wr_data_s;
  logic                           drop_s;
  logic                           closing_s;
  logic                           collision_r;
  logic [TAGWIDTH-1:0]            tg_s;

  // Per-entry write select: scanning lanes upward, the first lane to claim an
  // entry wins; later claimants and writes to already-set entries are dropped.
  always_comb begin
    wr_hit_s  = '0;
    wr_data_s = '0;
    drop_s    = 1'b0;
    tg_s      = '0;
    for (int l = 0; l < SIZE; l++) begin
      tg_s = tag[l*TAGWIDTH +: TAGWIDTH];
      if (lane_valid[l]) begin
        if (mask_r[tg_s] || wr_hit_s[tg_s]) begin
          drop_s = 1'b1;
        end else begin
          wr_hit_s[tg_s]  = 1'b1;
          wr_data_s[tg_s] = data[l*DWIDTH +: DWIDTH];
        end
      end else begin
        drop_s = drop_s;
      end
    end
  end

  // Next-state / mask logic; a bank closes on in_last or on a full mask.
  always_comb begin
    state_nxt_s = state_r;
    mask_nxt_s  = mask_r;
    closing_s   = 1'b0;
    case (state_r)
      FULL: begin
        if (rd_en) begin
          state_nxt_s = EMPTY;
          mask_nxt_s  = '0;
        end else begin
          state_nxt_s = FULL;
        end
      end
      EMPTY, FILLING: begin
        if (wr_en) begin
          mask_nxt_s = mask_r | wr_hit_s;
          if (last || (&(mask_r | wr_hit_s))) begin
            state_nxt_s = FULL;
            closing_s   = 1'b1;
          end else begin
            state_nxt_s = FILLING;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = EMPTY;
        mask_nxt_s  = '0;
      end
    endcase
  end

  // State, mask and collision-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= EMPTY;
      mask_r      <= '0;
      collision_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mask_r      <= mask_nxt_s;
      collision_r <= wr_en && drop_s;
    end
  end

  // Entry storage; no reset because the mask qualifies every entry.
  always_ff @(posedge clk) begin
    for (int t = 0; t < SIZE; t++) begin
      if (wr_en && wr_hit_s[t]) begin
        store_r[t] <= wr_data_s[t];
      end
    end
  end

  assign state     = state_r;
  assign mask      = mask_r;
  assign entries   = store_r;
  assign closing   = closing_s;
  assign collision = collision_r;

endmodule

// File: rtl/xbar_reorder_buf.sv
// Return-path reassembly buffer: scatters sorted lanes back to their source
// index in a ping-pong bank pair and presents each closed bank as one vector.
module xbar_reorder_buf
  import xbar_pkg::*;
#(
  parameter int SIZE     = XBAR_SIZE,
  parameter int DWIDTH   = XBAR_DWIDTH,
  parameter int TAGWIDTH = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE-1:0]          in_lane_valid,
  input  logic [SIZE*DWIDTH-1:0]   in_data,
  input  logic [SIZE*TAGWIDTH-1:0] in_tag,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*DWIDTH-1:0]   out_data,
  output logic [SIZE-1:0]          out_mask,
  output logic                     err_collision
);

  logic                   wr_sel_r;
  logic                   rd_sel_r;
  reorder_state_e         bank_state_s [2];
  logic [SIZE-1:0]        bank_mask_s  [2];
  logic [SIZE*DWIDTH-1:0] bank_data_s  [2];
  logic [1:0]             bank_close_s;
  logic [1:0]             bank_coll_s;
  logic [1:0]             wr_en_s;
  logic [1:0]             rd_en_s;
  logic                   accept_s;
  logic                   drain_s;
  logic [SIZE*DWIDTH-1:0] rd_data_s;

  // Handshakes depend only on registered bank state and the bank pointers.
  assign in_ready  = (bank_state_s[wr_sel_r] != FULL);
  assign out_valid = (bank_state_s[rd_sel_r] == FULL);
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = out_valid && out_ready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign wr_en_s[b] = accept_s && (wr_sel_r == 1'(b));
    assign rd_en_s[b] = drain_s  && (rd_sel_r == 1'(b));

    xbar_reorder_bank #(
      .SIZE     (SIZE),
      .DWIDTH   (DWIDTH),
      .TAGWIDTH (TAGWIDTH)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en_s[b]),
      .lane_valid (in_lane_valid),
      .data       (in_data),
      .tag        (in_tag),
      .last       (in_last),
      .rd_en      (rd_en_s[b]),
      .state      (bank_state_s[b]),
      .mask       (bank_mask_s[b]),
      .entries    (bank_data_s[b]),
      .closing    (bank_close_s[b]),
      .collision  (bank_coll_s[b])
    );
  end

  // Bank pointers: write side advances on close, read side on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_sel_r <= 1'b0;
      rd_sel_r <= 1'b0;
    end else begin
      wr_sel_r <= wr_sel_r ^ (|bank_close_s);
      rd_sel_r <= rd_sel_r ^ drain_s;
    end
  end

  // Output mux; lanes without a mask bit (or with no bank presented) read zero.
  always_comb begin
    rd_data_s = bank_data_s[rd_sel_r];
    out_data  = '0;
    if (out_valid) begin
      out_mask = bank_mask_s[rd_sel_r];
    end else begin
      out_mask = '0;
    end
    for (int t = 0; t < SIZE; t++) begin
      if (out_mask[t]) begin
        out_data[t*DWIDTH +: DWIDTH] = rd_data_s[t*DWIDTH +: DWIDTH];
      end else begin
        out_data[t*DWIDTH +: DWIDTH] = '0;
      end
    end
  end

  assign err_collision = |bank_coll_s;

endmodule
